// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and default parameter values.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } fetch_state_e;

    localparam logic [15:0] DefaultResetPc  = 16'h0000;
    localparam logic [15:0] DefaultLastPc   = 16'h001C;
    localparam logic [15:0] DefaultHaltWord = 16'hFFFF;

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: load takes a new instruction, squash clears only the valid bit,
// otherwise everything holds.
module ifid_register (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        squash_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc_o,
    output logic        valid_o
);

    logic [15:0] instr_d, instr_q;
    logic [15:0] pc_d, pc_q;
    logic        valid_d, valid_q;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end else if (squash_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 16'h0000;
            pc_q    <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, boot/run/halt control and issue counting,
// feeding an IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = DefaultResetPc,
    parameter logic [15:0] LAST_PC   = DefaultLastPc,
    parameter logic [15:0] HALT_WORD = DefaultHaltWord
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] ProgramCounter,
    input  logic [15:0] instructionIn,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [15:0] branchTarget,
    output logic [15:0] ifidInstruction,
    output logic [15:0] ifidPC,
    output logic        ifidValid,
    output logic        halted,
    output logic [15:0] fetchCount
);

    fetch_state_e state_d, state_q;
    logic [15:0]  pc_d, pc_q;
    logic [15:0]  count_d, count_q;
    logic         halted_d, halted_q;
    logic         ifid_load;
    logic         ifid_squash;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        ifid_load   = 1'b0;
        ifid_squash = 1'b0;
        unique case (state_q)
            StBoot: begin
                ifid_squash = 1'b1;
                state_d     = StRun;
            end
            StRun: begin
                if (branchTaken) begin
                    pc_d        = branchTarget & 16'hFFFE;
                    ifid_squash = 1'b1;
                end else if (stall) begin
                    // Everything holds while downstream is not ready.
                    pc_d = pc_q;
                end else if (pc_q > LAST_PC) begin
                    ifid_squash = 1'b1;
                    state_d     = StHalt;
                end else begin
                    ifid_load = 1'b1;
                    count_d   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    if (instructionIn == HALT_WORD) begin
                        state_d = StHalt;
                    end else begin
                        pc_d = pc_q + 16'd2;
                    end
                end
            end
            StHalt: begin
                ifid_squash = 1'b1;
            end
            default: begin
                ifid_squash = 1'b1;
                state_d     = StHalt;
            end
        endcase
        halted_d = (state_d == StHalt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StBoot;
            pc_q     <= RESET_PC;
            count_q  <= 16'h0000;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    ifid_register u_ifid_register (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ifid_load),
        .squash_i (ifid_squash),
        .instr_i  (instructionIn),
        .pc_i     (pc_q),
        .instr_o  (ifidInstruction),
        .pc_o     (ifidPC),
        .valid_o  (ifidValid)
    );

    assign ProgramCounter = pc_q;
    assign halted         = halted_q;
    assign fetchCount     = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/branch/reset
// traffic compared every cycle against a rule-based model of the fetch behaviour.
module tb_fetch_stage;

    localparam logic [15:0] LastPc   = 16'h001C;
    localparam logic [15:0] HaltWord = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] ProgramCounter;
    logic [15:0] instructionIn;
    logic        stall = 1'b0;
    logic        branchTaken = 1'b0;
    logic [15:0] branchTarget = 16'h0000;
    logic [15:0] ifidInstruction;
    logic [15:0] ifidPC;
    logic        ifidValid;
    logic        halted;
    logic [15:0] fetchCount;

    logic [15:0] rom [0:63];

    always #5 clk = ~clk;

    assign instructionIn = rom[ProgramCounter[6:1]];

    fetch_stage #(
        .RESET_PC  (16'h0000),
        .LAST_PC   (LastPc),
        .HALT_WORD (HaltWord)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ProgramCounter  (ProgramCounter),
        .instructionIn   (instructionIn),
        .stall           (stall),
        .branchTaken     (branchTaken),
        .branchTarget    (branchTarget),
        .ifidInstruction (ifidInstruction),
        .ifidPC          (ifidPC),
        .ifidValid       (ifidValid),
        .halted          (halted),
        .fetchCount      (fetchCount)
    );

    int total = 0;
    int bad = 0;
    bit cmp_on = 1'b0;

    // Model of the architecturally visible fetch state.
    logic [15:0] m_pc, m_instr, m_ipc, m_count;
    bit          m_valid, m_halted, m_boot;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc     = 16'h0000;
        m_instr  = 16'h0000;
        m_ipc    = 16'h0000;
        m_count  = 16'h0000;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_boot   = 1'b1;
    endfunction

    always @(posedge clk) begin : model_step
        logic [15:0] w;
        if (rst_n) begin
            if (m_boot) begin
                m_boot  = 1'b0;
                m_valid = 1'b0;
            end else if (m_halted) begin
                m_valid = 1'b0;
            end else if (branchTaken) begin
                m_pc    = branchTarget & 16'hFFFE;
                m_valid = 1'b0;
            end else if (stall) begin
                m_valid = m_valid;
            end else if (m_pc > LastPc) begin
                m_valid  = 1'b0;
                m_halted = 1'b1;
            end else begin
                w       = rom[m_pc[6:1]];
                m_instr = w;
                m_ipc   = m_pc;
                m_valid = 1'b1;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                if (w == HaltWord) m_halted = 1'b1;
                else m_pc = m_pc + 16'd2;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_pc", ProgramCounter, m_pc);
            chk("cyc_instr", ifidInstruction, m_instr);
            chk("cyc_ifidpc", ifidPC, m_ipc);
            chk("cyc_valid", {15'd0, ifidValid}, {15'd0, m_valid});
            chk("cyc_halted", {15'd0, halted}, {15'd0, m_halted});
            chk("cyc_count", fetchCount, m_count);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_pc", ProgramCounter, 16'h0000);
        chk("rst_instr", ifidInstruction, 16'h0000);
        chk("rst_ifidpc", ifidPC, 16'h0000);
        chk("rst_valid", {15'd0, ifidValid}, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'h0000);
        chk("rst_count", fetchCount, 16'h0000);
        @(negedge clk);
        rst_n       = 1'b1;
        stall       = 1'b0;
        branchTaken = 1'b0;
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 64; i++) rom[i] = 16'h1000 + 16'(i);
    endtask

    initial begin
        int hcnt;
        bit seen;
        fill_linear();
        model_reset();
        #1;
        rst_n  = 1'b0;
        cmp_on = 1'b1;

        // Straight-line program ending in a halt word.
        rom[0] = 16'h1111;
        rom[1] = 16'h2222;
        rom[2] = HaltWord;
        do_reset();
        @(negedge clk);
        chk("boot_pc", ProgramCounter, 16'h0000);
        chk("boot_valid", {15'd0, ifidValid}, 16'h0000);
        @(negedge clk);
        chk("i0_instr", ifidInstruction, 16'h1111);
        chk("i0_pc", ifidPC, 16'h0000);
        chk("i0_next_pc", ProgramCounter, 16'h0002);
        @(negedge clk);
        chk("i1_instr", ifidInstruction, 16'h2222);
        chk("i1_pc", ifidPC, 16'h0002);
        @(negedge clk);
        chk("i2_instr", ifidInstruction, 16'hFFFF);
        chk("i2_pc", ifidPC, 16'h0004);
        chk("i2_valid", {15'd0, ifidValid}, 16'h0001);
        chk("i2_halted", {15'd0, halted}, 16'h0001);
        chk("i2_hold_pc", ProgramCounter, 16'h0004);
        chk("model_count", m_count, 16'h0003);
        @(negedge clk);
        chk("h_valid", {15'd0, ifidValid}, 16'h0000);
        chk("h_count", fetchCount, 16'h0003);
        chk("model_halted", {15'd0, m_halted}, 16'h0001);

        // Reset out of HALT restarts from RESET_PC after one boot cycle.
        do_reset();
        @(negedge clk);
        chk("rb_boot_halted", {15'd0, halted}, 16'h0000);
        chk("rb_boot_valid", {15'd0, ifidValid}, 16'h0000);
        @(negedge clk);
        chk("rb_i0_instr", ifidInstruction, 16'h1111);
        chk("rb_i0_pc", ifidPC, 16'h0000);

        // Stall at PC 4, then branch with stall asserted.
        rom[2] = 16'h3333;
        do_reset();
        repeat (3) @(negedge clk);
        chk("st_pre_pc", ProgramCounter, 16'h0004);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("st_pc", ProgramCounter, 16'h0004);
            chk("st_instr", ifidInstruction, 16'h2222);
            chk("st_ifidpc", ifidPC, 16'h0002);
            chk("st_count", fetchCount, 16'h0002);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("st_resume_pc", ifidPC, 16'h0004);
        chk("st_resume_instr", ifidInstruction, 16'h3333);
        chk("st_resume_cnt", fetchCount, 16'h0003);
        chk("br_pre_pc", ProgramCounter, 16'h0006);
        branchTaken  = 1'b1;
        stall        = 1'b1;
        branchTarget = 16'h0011;
        @(negedge clk);
        chk("br_pc", ProgramCounter, 16'h0010);
        chk("br_valid", {15'd0, ifidValid}, 16'h0000);
        chk("br_count", fetchCount, 16'h0003);
        branchTaken = 1'b0;
        stall       = 1'b0;
        @(negedge clk);
        chk("br_issue_pc", ifidPC, 16'h0010);
        chk("br_issue_instr", ifidInstruction, 16'h1008);
        chk("model_br_ipc", m_ipc, 16'h0010);

        // Reset in the middle of a stall leaves nothing behind.
        stall = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();
        @(negedge clk);
        chk("rs_boot_valid", {15'd0, ifidValid}, 16'h0000);
        @(negedge clk);
        chk("rs_i0_pc", ifidPC, 16'h0000);
        chk("rs_i0_count", fetchCount, 16'h0001);

        // Run off the end of the ROM.
        fill_linear();
        do_reset();
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = halted;
        end
        chk("end_halt_seen", {15'd0, seen}, 16'h0001);
        chk("end_count", fetchCount, 16'd15);
        chk("end_pc", ProgramCounter, 16'h001E);
        chk("end_valid", {15'd0, ifidValid}, 16'h0000);
        chk("end_ifidpc", ifidPC, 16'h001C);

        // Randomized traffic.
        hcnt = 0;
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            if (m_halted) hcnt++;
            if ($urandom_range(0, 299) == 0 || hcnt > 3) begin
                for (int i = 0; i < 64; i++)
                    rom[i] = ($urandom_range(0, 19) == 0) ? HaltWord : 16'($urandom);
                hcnt = 0;
                do_reset();
            end else begin
                stall        = ($urandom_range(0, 3) == 0);
                branchTaken  = ($urandom_range(0, 9) == 0);
                branchTarget = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                           : 16'($urandom_range(0, 40));
            end
        end
        @(negedge clk);
        cmp_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
